// File: rtl/config_word_loader_pkg.sv
// Shared types and helpers for the configuration word loader.
package config_word_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam int          DATA_W_DEF    = 32;
    localparam int          NUM_WORDS_DEF = 19;
    localparam logic [31:0] CHK_SEED_DEF  = 32'hA5A5A5A5;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // A single-word bank still needs a 1-bit index.
    function automatic int addr_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/config_word_loader_if.sv
// Streamed configuration word port: start strobe plus valid/ready data.
interface config_word_loader_if #(
    parameter int DATA_W = 32
);
    logic              io_start;
    logic [DATA_W-1:0] io_d_in;
    logic              io_d_valid;
    logic              io_d_ready;

    modport master (output io_start, output io_d_in, output io_d_valid, input  io_d_ready);
    modport slave  (input  io_start, input  io_d_in, input  io_d_valid, output io_d_ready);
endinterface

// File: rtl/config_word_loader_bank.sv
// Shadow and active configuration storage with whole-bank commit and registered readback.
module config_word_bank
    import config_word_loader_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int ADDR_W    = addr_w(NUM_WORDS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_wr_en,
    input  logic [ADDR_W-1:0]           i_wr_idx,
    input  logic [DATA_W-1:0]           i_wr_data,
    input  logic                        i_commit,
    input  logic [ADDR_W-1:0]           i_rd_addr,
    output logic [DATA_W*NUM_WORDS-1:0] o_active_flat,
    output logic [DATA_W-1:0]           o_rd_data
);

    logic [DATA_W-1:0] r_shadow [NUM_WORDS];
    logic [DATA_W-1:0] r_active [NUM_WORDS];
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_in_range;

    assign w_rd_in_range = (32'(i_rd_addr) < 32'(NUM_WORDS));

    always_comb begin
        w_rd_data = '0;
        if (w_rd_in_range) begin
            w_rd_data = r_active[i_rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (i_wr_en) begin
                r_shadow[i_wr_idx] <= i_wr_data;
            end
            // Every active word switches on the same edge so the fabric never sees a mixed set.
            if (i_commit) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            r_rd_data <= w_rd_data;
        end
    end

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_flat
        assign o_active_flat[DATA_W*g +: DATA_W] = r_active[g];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/config_word_loader.sv
// Streams NUM_WORDS configuration words plus a trailing XOR checksum into shadow
// storage and commits them to the active configuration only when the checksum matches.
module config_word_loader
    import config_word_loader_pkg::*;
#(
    parameter int          DATA_W    = DATA_W_DEF,
    parameter int          NUM_WORDS = NUM_WORDS_DEF,
    parameter logic [31:0] CHK_SEED  = CHK_SEED_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    config_word_loader_if.slave            s_cfg,
    input  logic [addr_w(NUM_WORDS)-1:0]   io_rd_addr,
    output logic [DATA_W-1:0]              io_rd_data,
    output logic [DATA_W*NUM_WORDS-1:0]    io_configs_out,
    output logic                           io_configs_valid,
    output logic                           io_busy,
    output logic                           io_err
);

    localparam int                ADDR_W   = addr_w(NUM_WORDS);
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NUM_WORDS - 1);
    localparam logic [DATA_W-1:0] SEED     = DATA_W'(CHK_SEED);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0] r_chk;
    logic [DATA_W-1:0] w_chk_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_cfg_valid;
    logic              w_cfg_valid_nxt;
    logic              w_ready;
    logic              w_xfer;
    logic              w_wr_en;
    logic              w_commit;

    assign w_ready = (r_state != ST_IDLE) && !s_cfg.io_start;
    assign w_xfer  = s_cfg.io_d_valid && w_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_chk       <= SEED;
            r_err       <= 1'b0;
            r_cfg_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_chk       <= w_chk_nxt;
            r_err       <= w_err_nxt;
            r_cfg_valid <= w_cfg_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_chk_nxt       = r_chk;
        w_err_nxt       = r_err;
        w_cfg_valid_nxt = r_cfg_valid;
        w_wr_en         = 1'b0;
        w_commit        = 1'b0;
        // A start from any state restarts the sequence; ready is low so no word lands.
        if (s_cfg.io_start) begin
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = '0;
            w_chk_nxt   = SEED;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_xfer) begin
                        w_wr_en   = 1'b1;
                        w_chk_nxt = r_chk ^ s_cfg.io_d_in;
                        if (r_cnt == CNT_LAST) begin
                            w_state_nxt = ST_CHECK;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_xfer) begin
                        w_state_nxt = ST_IDLE;
                        if (s_cfg.io_d_in == r_chk) begin
                            w_commit        = 1'b1;
                            w_cfg_valid_nxt = 1'b1;
                            w_err_nxt       = 1'b0;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    config_word_bank #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_bank (
        .clk           (clk),
        .reset         (reset),
        .i_wr_en       (w_wr_en),
        .i_wr_idx      (r_cnt),
        .i_wr_data     (s_cfg.io_d_in),
        .i_commit      (w_commit),
        .i_rd_addr     (io_rd_addr),
        .o_active_flat (io_configs_out),
        .o_rd_data     (io_rd_data)
    );

    assign s_cfg.io_d_ready = w_ready;
    assign io_busy          = (r_state != ST_IDLE);
    assign io_err           = r_err;
    assign io_configs_valid = r_cfg_valid;

endmodule

// File: tb/tb_config_word_loader.sv
// Randomized bench for config_word_loader against a load-level reference model.
module tb_config_word_loader;

    localparam int          DW   = 32;
    localparam int          NW   = 19;
    localparam int          AW   = 5;
    localparam logic [31:0] SEED = 32'hA5A5A5A5;

    logic           clk = 1'b0;
    logic           reset;
    logic [AW-1:0]  io_rd_addr;
    logic [DW-1:0]  io_rd_data;
    logic [DW*NW-1:0] io_configs_out;
    logic           io_configs_valid;
    logic           io_busy;
    logic           io_err;

    config_word_loader_if #(.DATA_W(DW)) u_if ();

    config_word_loader #(
        .DATA_W    (DW),
        .NUM_WORDS (NW),
        .CHK_SEED  (SEED)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .s_cfg            (u_if),
        .io_rd_addr       (io_rd_addr),
        .io_rd_data       (io_rd_data),
        .io_configs_out   (io_configs_out),
        .io_configs_valid (io_configs_valid),
        .io_busy          (io_busy),
        .io_err           (io_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] words    [NW];
    logic [DW-1:0] m_active [NW];
    logic          m_valid;
    logic          m_err;

    task automatic check_val(input string tag, input logic [DW*NW-1:0] obs, input logic [DW*NW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW*NW-1:0] model_flat();
        logic [DW*NW-1:0] f;
        f = '0;
        for (int i = 0; i < NW; i++) f[DW*i +: DW] = m_active[i];
        return f;
    endfunction

    function automatic logic [DW-1:0] calc_chk();
        logic [DW-1:0] c;
        c = SEED;
        for (int i = 0; i < NW; i++) c = c ^ words[i];
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NW; i++) m_active[i] = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_cfg"},   io_configs_out, model_flat());
        check_val({tag, "_valid"}, io_configs_valid, m_valid);
        check_val({tag, "_err"},   io_err, m_err);
        check_val({tag, "_busy"},  io_busy, 1'b0);
        check_val({tag, "_ready"}, u_if.io_d_ready, 1'b0);
    endtask

    // Called at a falling edge; the start is taken on the next rising edge.
    task automatic do_start(input logic with_valid);
        u_if.io_start   = 1'b1;
        u_if.io_d_valid = with_valid;
        u_if.io_d_in    = $urandom;
        #1 check_val("start_ready", u_if.io_d_ready, 1'b0);
        @(negedge clk);
        u_if.io_start   = 1'b0;
        u_if.io_d_valid = 1'b0;
        m_err = 1'b0;
        #1;
        check_val("start_busy", io_busy, 1'b1);
        check_val("start_err",  io_err, m_err);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int gap);
        for (int g = 0; g < gap; g++) begin
            u_if.io_d_valid = 1'b0;
            u_if.io_d_in    = $urandom;
            @(negedge clk);
        end
        u_if.io_d_valid = 1'b1;
        u_if.io_d_in    = w;
        #1 check_val("word_ready", u_if.io_d_ready, 1'b1);
        @(negedge clk);
        u_if.io_d_valid = 1'b0;
    endtask

    // Streams words[] then the given checksum, updates the model, checks the result.
    task automatic load_words(input int gmin, input int gmax, input logic [DW-1:0] cs, input string tag);
        for (int i = 0; i < NW; i++) send_word(words[i], $urandom_range(gmax, gmin));
        send_word(cs, $urandom_range(gmax, gmin));
        if (cs == calc_chk()) begin
            for (int i = 0; i < NW; i++) m_active[i] = words[i];
            m_valid = 1'b1;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        #1 check_idle_outputs(tag);
    endtask

    task automatic rd_check(input logic [AW-1:0] a);
        logic [DW-1:0] exp;
        io_rd_addr = a;
        exp = (int'(a) < NW) ? m_active[a] : '0;
        @(negedge clk);
        #1 check_val("rd_data", io_rd_data, exp);
    endtask

    task automatic abort_after(input int n);
        do_start(1'($urandom_range(1, 0)));
        for (int i = 0; i < n; i++) send_word($urandom, $urandom_range(1, 0));
        u_if.io_start   = 1'b1;
        u_if.io_d_valid = 1'b1;
        u_if.io_d_in    = 32'hDEADBEEF;
        #1 check_val("abort_ready", u_if.io_d_ready, 1'b0);
        @(negedge clk);
        u_if.io_start   = 1'b0;
        u_if.io_d_valid = 1'b0;
        m_err = 1'b0;
        #1;
        check_val("abort_busy", io_busy, 1'b1);
        check_val("abort_err",  io_err, m_err);
        check_val("abort_cfg",  io_configs_out, model_flat());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [DW-1:0] mask;
        reset           = 1'b1;
        u_if.io_start   = 1'b0;
        u_if.io_d_valid = 1'b0;
        u_if.io_d_in    = '0;
        io_rd_addr      = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        #1 check_idle_outputs("reset");
        check_val("reset_rd", io_rd_data, '0);
        @(negedge clk);
        reset = 1'b0;

        // Good load of 1..19, checksum equals the seed.
        for (int i = 0; i < NW; i++) words[i] = DW'(i + 1);
        do_start(1'b1);
        load_words(0, 0, 32'hA5A5A5A5, "good");
        check_val("good_w0",  io_configs_out[31:0], 32'h1);
        check_val("good_w18", io_configs_out[607:576], 32'h13);
        rd_check(5'd18);
        rd_check(5'd19);
        rd_check(5'd0);

        // Same words with an idle cycle before every transfer.
        do_start(1'b0);
        load_words(1, 1, 32'hA5A5A5A5, "gaps");

        // Bad checksum keeps the previous configuration.
        for (int i = 0; i < NW; i++) words[i] = DW'(32'h100 + i);
        do_start(1'b1);
        load_words(0, 1, 32'h0, "bad");
        check_val("bad_w18", io_configs_out[607:576], 32'h13);
        rd_check(5'd18);

        // Abort after 5 words, then a complete good sequence without a new start.
        abort_after(5);
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        load_words(0, 1, calc_chk(), "abort");

        // Randomized loads with occasional corruption and aborts.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NW; i++) words[i] = $urandom;
            if (it % 3 == 2) abort_after($urandom_range(NW - 1, 0));
            else do_start(1'($urandom_range(1, 0)));
            mask = ($urandom_range(2, 0) == 0) ? (32'h1 << $urandom_range(31, 0)) : 32'h0;
            load_words(0, 2, calc_chk() ^ mask, "rand");
            for (int r = 0; r < 3; r++) rd_check(AW'($urandom_range(31, 0)));
        end

        // Asynchronous reset in the middle of a load.
        do_start(1'b0);
        for (int i = 0; i < 5; i++) send_word($urandom, 0);
        u_if.io_d_valid = 1'b1;
        reset = 1'b1;
        model_clear();
        #1;
        check_idle_outputs("midrst");
        check_val("midrst_rd", io_rd_data, '0);
        @(negedge clk);
        u_if.io_d_valid = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < NW; i++) words[i] = $urandom;
        do_start(1'b1);
        load_words(0, 1, calc_chk(), "recover");
        rd_check(5'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/config_word_loader.md
Name: config_word_loader

Overview:
- Parametrised successor to the per-word configuration latches.
- Replaces the level-sensitive enable-per-word latches with flip-flop storage, loaded by a streamed valid/ready word sequence with an auto-incrementing word counter.
- A trailing checksum word guards the stream. Shadow registers commit to the active configuration atomically, only on a checksum match.
- Sits between the tile configuration port and the tile fabric. It drives the flat configuration bus consumed by LUTs and routing muxes.

Parameters:
- DATA_W, 32, width of one configuration word.
- NUM_WORDS, 19, number of configuration words per tile (>=1).
- CHK_SEED, 32'hA5A5A5A5, initial value of the running checksum; truncated or zero-extended to DATA_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- io_start  input  1  begin (or restart) a load sequence.
- io_d_in  input  DATA_W  streamed configuration or checksum word.
- io_d_valid  input  1  io_d_in is valid.
- io_d_ready  output  1  loader accepts io_d_in this cycle.
- io_rd_addr  input  clog2(NUM_WORDS)  readback word index (min width 1).
- io_rd_data  output  DATA_W  registered readback of the addressed active word.
- io_configs_out  output  DATA_W*NUM_WORDS  active configuration; word i occupies bits [DATA_W*(i+1)-1 : DATA_W*i].
- io_configs_valid  output  1  active configuration holds a checksum-verified load.
- io_busy  output  1  a load is in progress.
- io_err  output  1  last load failed its checksum.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; counter=0; chk=CHK_SEED.
  - Shadow and active words all 0.
  - io_configs_valid=0, io_err=0, io_rd_data=0.
- States: IDLE, LOAD, CHECK.
- Handshake: io_d_ready = (state!=IDLE) && !io_start (combinational). A word transfers on an edge where io_d_valid && io_d_ready. io_busy = (state!=IDLE).
- IDLE: on io_start -> LOAD; counter=0; chk=CHK_SEED; io_err cleared to 0.
- LOAD, on transfer:
  - shadow[counter] <= io_d_in; chk <= chk ^ io_d_in.
  - If counter==NUM_WORDS-1 -> CHECK, else counter+1.
  - No transfer: hold all state.
- CHECK, on transfer:
  - io_d_in==chk: active <= shadow (all words, same edge); io_configs_valid <= 1; io_err <= 0; -> IDLE.
  - Mismatch: active unchanged; io_configs_valid unchanged; io_err <= 1; -> IDLE.
- Latency: io_configs_out reflects the new configuration the cycle after the checksum handshake edge.
- io_start in LOAD or CHECK aborts the load:
  - Restart as from IDLE: counter=0, chk=CHK_SEED, io_err=0.
  - No word is accepted that cycle (ready low).
  - Active configuration is untouched; partial shadow contents are irrelevant.
- io_start with io_d_valid in IDLE: only the start is taken; no data is accepted.
- io_configs_valid is sticky after the first successful commit. Failed or aborted loads never clear it or alter active words.
- Readback: io_rd_data <= active[io_rd_addr] each cycle (1-cycle latency). io_rd_addr >= NUM_WORDS returns 0.
- Counter never exceeds NUM_WORDS-1. NUM_WORDS=1 goes LOAD -> CHECK after one word.

Decomposition:
- Shared package: state enum (IDLE/LOAD/CHECK), clog2 helper, CNT_W/ADDR_W derivation, default checksum seed constant.
- One sub-module, config_word_bank: shadow plus active storage, per-word write enable, whole-bank commit strobe, registered readback mux.
- The FSM, counter and checksum stay in config_word_loader.

Test Plan:
- Reset mid-stream (assert reset during LOAD) -> same cycle: io_configs_out=0, io_busy=0, io_d_ready=0, io_configs_valid=0, io_err=0.
- Good load: start, words 0x1..0x13, then checksum 0xA5A5A5A5 (XOR of 1..19 is 0). Required response one cycle after the checksum edge:
  - io_configs_out[31:0]=0x1 and [607:576]=0x13.
  - io_configs_valid=1, io_err=0, io_busy=0.
- Backpressure and gaps: same words with io_d_valid low on alternate cycles -> identical final configuration; word count unaffected by idle cycles.
- Bad checksum: after the good load, send words 0x100..0x112 with checksum 0x0. Required response:
  - io_err=1, io_configs_valid=1.
  - io_configs_out still holds 0x1..0x13.
- Abort: start, send 5 words, pulse io_start with io_d_valid high, then a full good sequence -> word during start not stored; commit contains only the new 19 words.
- Readback: io_rd_addr=18 -> io_rd_data=0x13 next cycle; io_rd_addr=19 -> 0 next cycle.
